// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO byte FIFO feeding a UART serialiser, 8N1 by default, 8E1 with MMIO_UART_TX_PARITY_EN.
// Latency: a store at edge E0 starts the start bit on edge E1; read data and hit are combinational.
// Backpressure: none on the bus; a store to a full FIFO is dropped and sets the sticky overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_ena,
    output logic [31:0] mem_rd_data,
    output logic        hit,
    output logic        txd,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [PTR_W-1:0] head, tail, count;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [7:0]       head_byte;
    logic             full, empty, overflow;
    logic             sel_data, sel_stat, push_req, clr_req, push, pop;
    logic [31:0]      count_w;
    logic [3:0]       count_sat;

    state_t           state, state_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shreg, shreg_d;
    logic             txd_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             parity, parity_d;
`endif

    wire unused_wr_hi = ^mem_wr_data[31:8];

    // Address decode and bus-side status
    assign sel_data = (mem_addr == BASE_ADDR);
    assign sel_stat = (mem_addr == BASE_ADDR + 32'd4);
    assign hit      = sel_data | sel_stat;
    assign push_req = mem_wr_ena & sel_data;
    assign clr_req  = mem_wr_ena & sel_stat;

    assign empty     = (head == tail);
    assign full      = (head[PTR_W-1] != tail[PTR_W-1]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
    assign count     = tail - head;
    assign count_w   = 32'(count);
    assign count_sat = (count_w > 32'd15) ? 4'hF : count_w[3:0];
    assign push      = push_req & (~full | pop);
    assign head_byte = mem[head[IDX_W-1:0]];
    assign busy      = (state != ST_IDLE);

    assign mem_rd_data = sel_stat ? {24'd0, count_sat, overflow, busy, empty, full} : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (clr_req)
                overflow <= 1'b0;
            else if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail[IDX_W-1:0]] <= mem_wr_data[7:0];
    end

    // txd is registered, so each branch computes the level for the state being entered
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        txd_d      = txd;
        pop        = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d   = parity;
`endif
        case (state)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    state_d    = ST_START;
                    baud_cnt_d = CNT_RELOAD;
                    shreg_d    = head_byte;
                    txd_d      = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
                    parity_d   = ^head_byte;
`endif
                end
            end
            ST_START: begin
                if (baud_cnt == '0) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = CNT_RELOAD;
                    bit_idx_d  = 3'd0;
                    txd_d      = shreg[0];
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_d = CNT_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shreg_d   = {1'b0, shreg[7:1]};
                        txd_d     = shreg[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_cnt == '0) begin
                    state_d    = ST_STOP;
                    baud_cnt_d = CNT_RELOAD;
                    txd_d      = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_cnt == '0) begin
                    baud_cnt_d = CNT_RELOAD;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                        shreg_d = head_byte;
                        txd_d   = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
                        parity_d = ^head_byte;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            txd      <= txd_d;
`ifdef MMIO_UART_TX_PARITY_EN
            parity   <= parity_d;
`endif
        end
    end
endmodule
